// File: rtl/dkong_snd_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dkong_snd_arb_pkg
//  Purpose  : Shared types and constants for the Donkey Kong sound-board
//             ROM read arbiter (FSM states, requester ids, fill byte,
//             starvation counter sizing).
//  Revision : 1.0 - initial release
// ============================================================================
package dkong_snd_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_WAIT = 2'd1,
        WAV_WAIT = 2'd2
    } arb_state_e;

    // Requester identity used by the grant decision
    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_WAV = 1'b1
    } req_id_e;

    // Byte handed to a consumer when its read is abandoned
    localparam logic [7:0] TIMEOUT_FILL = 8'hFF;

    // Width of the WAV starvation counter (saturates at all-ones)
    localparam int STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_MAX = {STARVE_W{1'b1}};

    // Saturating increment for the starvation counter
    function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
        return (cnt == STARVE_MAX) ? cnt : cnt + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dkong_snd_rom_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dkong_snd_rom_arbiter_if
//  Purpose  : Byte-wide shared memory read port between the sound ROM
//             arbiter (master) and the top-level memory controller (slave).
//             Signal names are written from the arbiter's point of view.
//  Revision : 1.0 - initial release
// ============================================================================
interface dkong_snd_rom_arbiter_if #(
    parameter int MEM_AW = 25
);
    logic [MEM_AW-1:0] O_MEM_A;    // byte address, held between grants
    logic              O_MEM_RD;   // one-cycle read strobe
    logic [7:0]        I_MEM_D;    // read data, valid with I_MEM_ACK
    logic              I_MEM_ACK;  // one-cycle read-complete pulse

    modport master (
        output O_MEM_A,
        output O_MEM_RD,
        input  I_MEM_D,
        input  I_MEM_ACK
    );

    modport slave (
        input  O_MEM_A,
        input  O_MEM_RD,
        output I_MEM_D,
        output I_MEM_ACK
    );
endinterface
`default_nettype wire

// File: rtl/dkong_snd_arb_port.sv
`default_nettype none
// ============================================================================
//  Module   : dkong_snd_arb_port
//  Purpose  : One requester slot of the sound ROM arbiter. Holds the last
//             byte delivered, the address it belongs to and a loaded flag,
//             and derives pending / valid against the live input address.
//  Revision : 1.0 - initial release
// ============================================================================
module dkong_snd_arb_port #(
    parameter int AW = 12
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [AW-1:0] addr_i,       // live requester address
    input  logic          load_i,       // read finished (ack or timeout)
    input  logic [AW-1:0] load_addr_i,  // address the finished read was for
    input  logic [7:0]    load_data_i,  // byte to present to the consumer
    output logic [7:0]    data_o,
    output logic          valid_o,
    output logic          pending_o
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;
    logic [7:0]    data_q;
    logic [7:0]    data_d;
    logic          loaded_q;
    logic          loaded_d;

    // Capture a finished read; otherwise hold what the consumer sees
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        loaded_d = loaded_q;
        if (load_i) begin
            addr_d   = load_addr_i;
            data_d   = load_data_i;
            loaded_d = 1'b1;
        end
    end

    // Slot registers, cleared asynchronously on reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q   <= '0;
            data_q   <= 8'h00;
            loaded_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            loaded_q <= loaded_d;
        end
    end

    // The held byte is only meaningful while the input still points at it;
    // anything else means a fresh read is needed.
    assign valid_o   = loaded_q && (addr_q == addr_i);
    assign pending_o = !valid_o;
    assign data_o    = data_q;

endmodule
`default_nettype wire

// File: rtl/dkong_snd_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dkong_snd_rom_arbiter
//  Purpose  : Shares one byte-wide memory read port between the 8035 sound
//             CPU program ROM (12-bit address) and the WAV sample stream
//             (19-bit address). Address changes trigger single-byte reads;
//             returned bytes are held for the consumers with a VALID flag.
//             CPU has priority unless WAV has lost WAV_STARVE times in a row.
//  Options  : DKONG_SND_ARB_STATS_EN - adds O_MAX_LAT, worst-case CPU
//             request-to-valid latency in cycles (saturating at 255).
//  Revision : 1.0 - initial release
// ============================================================================
module dkong_snd_rom_arbiter
    import dkong_snd_arb_pkg::*;
#(
    parameter int                MEM_AW     = 25,
    parameter logic [MEM_AW-1:0] CPU_BASE   = 25'h0000000,
    parameter logic [MEM_AW-1:0] WAV_BASE   = 25'h0010000,
    parameter int                WAV_STARVE = 4,
    parameter int                TIMEOUT    = 255
) (
    input  logic                    W_CLK_24576M,
    input  logic                    W_RESETn,
    input  logic [11:0]             I_CPU_A,
    output logic [7:0]              O_CPU_D,
    output logic                    O_CPU_VALID,
    input  logic [18:0]             I_WAV_A,
    output logic [7:0]              O_WAV_D,
    output logic                    O_WAV_VALID,
    dkong_snd_rom_arbiter_if.master mem,
    output logic                    O_TIMEOUT_ERR
`ifdef DKONG_SND_ARB_STATS_EN
    ,
    output logic [7:0]              O_MAX_LAT
`endif
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(WAV_STARVE);
    localparam logic [7:0]          TMO_LAST   = 8'(TIMEOUT - 1);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [MEM_AW-1:0] mem_a_q;
    logic [MEM_AW-1:0] mem_a_d;
    logic              mem_rd_q;
    logic              mem_rd_d;
    logic [11:0]       cpu_iss_q;
    logic [11:0]       cpu_iss_d;
    logic [18:0]       wav_iss_q;
    logic [18:0]       wav_iss_d;
    logic [7:0]        tmo_q;
    logic [7:0]        tmo_d;
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
    logic              err_q;
    logic              err_d;

    logic              cpu_pend;
    logic              wav_pend;
    logic              cpu_load;
    logic              wav_load;
    logic [7:0]        load_data;
    logic              tmo_hit;
    req_id_e           gnt_id;

    // ------------------------------------------------------------------
    // Requester slots
    // ------------------------------------------------------------------
    dkong_snd_arb_port #(
        .AW (12)
    ) u_cpu_port (
        .clk_i       (W_CLK_24576M),
        .rst_n_i     (W_RESETn),
        .addr_i      (I_CPU_A),
        .load_i      (cpu_load),
        .load_addr_i (cpu_iss_q),
        .load_data_i (load_data),
        .data_o      (O_CPU_D),
        .valid_o     (O_CPU_VALID),
        .pending_o   (cpu_pend)
    );

    dkong_snd_arb_port #(
        .AW (19)
    ) u_wav_port (
        .clk_i       (W_CLK_24576M),
        .rst_n_i     (W_RESETn),
        .addr_i      (I_WAV_A),
        .load_i      (wav_load),
        .load_addr_i (wav_iss_q),
        .load_data_i (load_data),
        .data_o      (O_WAV_D),
        .valid_o     (O_WAV_VALID),
        .pending_o   (wav_pend)
    );

    // A real ack always wins; the fill byte is only used on abandonment
    assign load_data = mem.I_MEM_ACK ? mem.I_MEM_D : TIMEOUT_FILL;
    assign tmo_hit   = (tmo_q == TMO_LAST);

    // Next-state, grant decision and read-completion handling
    always_comb begin
        state_d   = state_q;
        mem_a_d   = mem_a_q;
        mem_rd_d  = 1'b0;
        cpu_iss_d = cpu_iss_q;
        wav_iss_d = wav_iss_q;
        tmo_d     = tmo_q;
        starve_d  = starve_q;
        err_d     = err_q;
        cpu_load  = 1'b0;
        wav_load  = 1'b0;
        gnt_id    = REQ_CPU;

        case (state_q)
            IDLE: begin
                // WAV wins when it is the only one asking or has starved
                if (wav_pend && (!cpu_pend || (starve_q >= STARVE_LIM))) begin
                    gnt_id = REQ_WAV;
                end
                if (cpu_pend || wav_pend) begin
                    mem_rd_d = 1'b1;
                    tmo_d    = 8'h00;
                    if (gnt_id == REQ_WAV) begin
                        state_d   = WAV_WAIT;
                        wav_iss_d = I_WAV_A;
                        mem_a_d   = WAV_BASE + MEM_AW'(I_WAV_A);
                        starve_d  = '0;
                    end else begin
                        state_d   = CPU_WAIT;
                        cpu_iss_d = I_CPU_A;
                        mem_a_d   = CPU_BASE + MEM_AW'(I_CPU_A);
                        if (wav_pend) begin
                            starve_d = starve_inc(starve_q);
                        end
                    end
                end
            end

            CPU_WAIT: begin
                if (mem.I_MEM_ACK) begin
                    cpu_load = 1'b1;
                    state_d  = IDLE;
                end else if (tmo_hit) begin
                    cpu_load = 1'b1;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            WAV_WAIT: begin
                if (mem.I_MEM_ACK) begin
                    wav_load = 1'b1;
                    state_d  = IDLE;
                end else if (tmo_hit) begin
                    wav_load = 1'b1;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state register; reset abandons any read in flight
    always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            state_q   <= IDLE;
            mem_a_q   <= '0;
            mem_rd_q  <= 1'b0;
            cpu_iss_q <= '0;
            wav_iss_q <= '0;
            tmo_q     <= 8'h00;
            starve_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_a_q   <= mem_a_d;
            mem_rd_q  <= mem_rd_d;
            cpu_iss_q <= cpu_iss_d;
            wav_iss_q <= wav_iss_d;
            tmo_q     <= tmo_d;
            starve_q  <= starve_d;
            err_q     <= err_d;
        end
    end

    assign mem.O_MEM_A    = mem_a_q;
    assign mem.O_MEM_RD   = mem_rd_q;
    assign O_TIMEOUT_ERR  = err_q;

`ifdef DKONG_SND_ARB_STATS_EN
    // ------------------------------------------------------------------
    // CPU latency statistics: count pending cycles since the last address
    // change and keep the largest count seen when VALID rises.
    // ------------------------------------------------------------------
    logic [11:0] lat_a_q;
    logic [7:0]  lat_cnt_q;
    logic [7:0]  lat_max_q;
    logic        lat_vld_q;

    // Latency counter and running maximum
    always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
        if (!W_RESETn) begin
            lat_a_q   <= '0;
            lat_cnt_q <= 8'h00;
            lat_max_q <= 8'h00;
            lat_vld_q <= 1'b0;
        end else begin
            lat_a_q   <= I_CPU_A;
            lat_vld_q <= O_CPU_VALID;
            if (I_CPU_A != lat_a_q) begin
                lat_cnt_q <= 8'h00;
            end else if (cpu_pend && (lat_cnt_q != 8'hFF)) begin
                lat_cnt_q <= lat_cnt_q + 8'd1;
            end
            if (O_CPU_VALID && !lat_vld_q && (lat_cnt_q > lat_max_q)) begin
                lat_max_q <= lat_cnt_q;
            end
        end
    end

    assign O_MAX_LAT = lat_max_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dkong_snd_rom_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_dkong_snd_rom_arbiter
//  Purpose  : Directed self-checking bench for dkong_snd_rom_arbiter.
//             A second instance with a high WAV_BASE and a short timeout
//             exercises address wrap and CPU-side abandonment.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dkong_snd_rom_arbiter;

    localparam logic [24:0] C_WAV_BASE  = 25'h0010000;
    localparam logic [24:0] C_WAV_BASE2 = 25'h1FF0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] cpu_a;
    logic [18:0] wav_a;
    logic [7:0]  cpu_d, wav_d;
    logic        cpu_valid, wav_valid, tmo_err;
    logic [7:0]  cpu_d2, wav_d2;
    logic        cpu_valid2, wav_valid2, tmo_err2;

    logic        resp_ack;
    logic [7:0]  resp_d;
    logic        spur_ack;
    logic        block_wav;
    logic        mon_en;
    logic [9:0]  pat;
    int          gn;
    int          n_checks = 0;
    int          n_errors = 0;

`ifdef DKONG_SND_ARB_STATS_EN
    logic [7:0]  max_lat, max_lat2;
`endif

    always #10 clk = ~clk;

    dkong_snd_rom_arbiter_if #(.MEM_AW(25)) mif ();
    dkong_snd_rom_arbiter_if #(.MEM_AW(25)) mif2 ();

    assign mif.I_MEM_ACK  = resp_ack | spur_ack;
    assign mif.I_MEM_D    = spur_ack ? 8'h77 : resp_d;
    assign mif2.I_MEM_ACK = 1'b0;
    assign mif2.I_MEM_D   = 8'h5A;

    dkong_snd_rom_arbiter u_dut (
        .W_CLK_24576M  (clk),
        .W_RESETn      (rst_n),
        .I_CPU_A       (cpu_a),
        .O_CPU_D       (cpu_d),
        .O_CPU_VALID   (cpu_valid),
        .I_WAV_A       (wav_a),
        .O_WAV_D       (wav_d),
        .O_WAV_VALID   (wav_valid),
        .mem           (mif.master),
        .O_TIMEOUT_ERR (tmo_err)
`ifdef DKONG_SND_ARB_STATS_EN
        ,
        .O_MAX_LAT     (max_lat)
`endif
    );

    dkong_snd_rom_arbiter #(
        .WAV_BASE (C_WAV_BASE2),
        .TIMEOUT  (2)
    ) u_dut2 (
        .W_CLK_24576M  (clk),
        .W_RESETn      (rst_n),
        .I_CPU_A       (12'h000),
        .O_CPU_D       (cpu_d2),
        .O_CPU_VALID   (cpu_valid2),
        .I_WAV_A       (19'h7FFFF),
        .O_WAV_D       (wav_d2),
        .O_WAV_VALID   (wav_valid2),
        .mem           (mif2.master),
        .O_TIMEOUT_ERR (tmo_err2)
`ifdef DKONG_SND_ARB_STATS_EN
        ,
        .O_MAX_LAT     (max_lat2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Memory model: ack 3 cycles after RD with the address low byte
    initial begin
        logic [24:0] a;
        resp_ack = 1'b0;
        resp_d   = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (mif.O_MEM_RD) begin
                a = mif.O_MEM_A;
                if (!(block_wav && (a >= C_WAV_BASE))) begin
                    repeat (3) @(posedge clk);
                    #1;
                    resp_ack = 1'b1;
                    resp_d   = a[7:0];
                    @(posedge clk);
                    #1;
                    resp_ack = 1'b0;
                end
            end
        end
    end

    // Grant monitor: bit k of pat is 1 when grant k went to WAV
    initial begin
        pat = '0;
        gn  = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && mif.O_MEM_RD && (gn < 10)) begin
                pat[gn] = (mif.O_MEM_A >= C_WAV_BASE);
                gn++;
            end
        end
    end

    task automatic wait_valid(input bit wav, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = wav ? wav_valid : cpu_valid;
        end
        chk(wav ? "wait_wav_valid" : "wait_cpu_valid", {31'd0, seen}, 32'd1);
    endtask

    initial begin
        cpu_a     = 12'h000;
        wav_a     = 19'h00000;
        spur_ack  = 1'b0;
        block_wav = 1'b0;
        mon_en    = 1'b0;

        // ---- reset values ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_d",   cpu_d,       0);
        chk("rst_wav_d",   wav_d,       0);
        chk("rst_cpu_vld", cpu_valid,   0);
        chk("rst_wav_vld", wav_valid,   0);
        chk("rst_rd",      mif.O_MEM_RD, 0);
        chk("rst_mem_a",   mif.O_MEM_A, 0);
        chk("rst_err",     tmo_err,     0);

        // ---- test 1: CPU first, then WAV ----
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;                       // R0: CPU grant
        chk("t1_cpu_rd",   mif.O_MEM_RD, 1);
        chk("t1_cpu_a",    mif.O_MEM_A,  0);
        @(posedge clk); #1;                       // R1
        chk("t1_rd_pulse", mif.O_MEM_RD, 0);
        @(posedge clk); #1;                       // R2: dut2 CPU timed out
        chk("t5_cpu_fill", cpu_d2,     8'hFF);
        chk("t5_cpu_vld",  cpu_valid2, 1);
        chk("t5_err",      tmo_err2,   1);
        @(posedge clk); #1;                       // R3: dut2 WAV grant, wrapped
        chk("t5_wrap_a",   mif2.O_MEM_A, 25'h006FFFF);
        chk("t5_wrap_rd",  mif2.O_MEM_RD, 1);
        chk("t5_no_x",     {31'd0, $isunknown(mif2.O_MEM_A)}, 0);
        @(posedge clk); #1;                       // R4: CPU ack consumed
        chk("t1_cpu_vld",  cpu_valid, 1);
        chk("t1_cpu_d",    cpu_d,     8'h00);
        chk("t1_wav_vld0", wav_valid, 0);
        @(posedge clk); #1;                       // R5: WAV grant
        chk("t1_wav_rd",   mif.O_MEM_RD, 1);
        chk("t1_wav_a",    mif.O_MEM_A,  25'h0010000);
        repeat (4) @(posedge clk); #1;            // R9
        chk("t1_wav_vld",  wav_valid, 1);
        chk("t1_wav_d",    wav_d,     8'h00);
        chk("t1_err",      tmo_err,   0);

        // ---- test 3: CPU address changes while in flight ----
        cpu_a = 12'h010;
        @(posedge clk); #1;
        chk("t3_rd1",      mif.O_MEM_RD, 1);
        chk("t3_a1",       mif.O_MEM_A,  25'h0000010);
        cpu_a = 12'h011;
        repeat (4) @(posedge clk); #1;
        chk("t3_vld_lo",   cpu_valid, 0);
        chk("t3_d_old",    cpu_d,     8'h10);
        @(posedge clk); #1;
        chk("t3_rd2",      mif.O_MEM_RD, 1);
        chk("t3_a2",       mif.O_MEM_A,  25'h0000011);
        repeat (4) @(posedge clk); #1;
        chk("t3_vld",      cpu_valid, 1);
        chk("t3_d",        cpu_d,     8'h11);

        // ---- test 4: WAV read never acknowledged ----
        block_wav = 1'b1;
        wav_a     = 19'h00123;
        @(posedge clk); #1;                       // Q: grant
        chk("t4_rd",       mif.O_MEM_RD, 1);
        chk("t4_a",        mif.O_MEM_A,  25'h0010123);
        repeat (254) @(posedge clk); #1;          // Q+254: still waiting
        chk("t4_vld_pre",  wav_valid, 0);
        chk("t4_err_pre",  tmo_err,   0);
        @(posedge clk); #1;                       // Q+255: abandoned
        chk("t4_fill",     wav_d,     8'hFF);
        chk("t4_vld",      wav_valid, 1);
        chk("t4_err",      tmo_err,   1);
        spur_ack = 1'b1;
        @(posedge clk); #1;
        spur_ack = 1'b0;
        chk("t4_spur_wav", wav_d,     8'hFF);
        chk("t4_spur_vld", wav_valid, 1);
        chk("t4_spur_cpu", cpu_d,     8'h11);
        chk("t4_spur_rd",  mif.O_MEM_RD, 0);
        block_wav = 1'b0;
        cpu_a     = 12'h022;
        wait_valid(1'b0, 20);
        chk("t4_after_d",  cpu_d,   8'h22);
        chk("t4_sticky",   tmo_err, 1);

        // ---- test 2: both change every cycle, WAV starvation ----
        mon_en = 1'b1;
        for (int i = 0; i < 55; i++) begin
            cpu_a = cpu_a + 12'd1;
            wav_a = wav_a + 19'd1;
            @(posedge clk); #1;
        end
        mon_en = 1'b0;
        chk("t2_grants",   gn,  10);
        chk("t2_pattern",  pat, 10'h210);
        wait_valid(1'b0, 30);
        wait_valid(1'b1, 30);
        chk("t2_cpu_d",    cpu_d, {24'd0, cpu_a[7:0]});
        chk("t2_wav_d",    wav_d, {24'd0, wav_a[7:0]});

        // ---- test 6: reset during WAV_WAIT ----
        block_wav = 1'b1;
        wav_a     = 19'h00456;
        @(posedge clk); #1;
        chk("t6_rd",       mif.O_MEM_RD, 1);
        chk("t6_a",        mif.O_MEM_A,  25'h0010456);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rd0",      mif.O_MEM_RD, 0);
        chk("t6_a0",       mif.O_MEM_A,  0);
        chk("t6_cpu_d",    cpu_d,     0);
        chk("t6_wav_d",    wav_d,     0);
        chk("t6_cpu_vld",  cpu_valid, 0);
        chk("t6_wav_vld",  wav_valid, 0);
        chk("t6_err",      tmo_err,   0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dkong_snd_rom_arbiter.md
Name: dkong_snd_rom_arbiter

Overview:
Shares one external byte-wide memory read port (SDRAM/DDR bridge) between two sound-board requesters: the 8035 sound CPU program ROM (12-bit address) and the analog WAV sample stream (19-bit address). It detects address changes on each requester and issues single-byte reads with a req/ack handshake. It holds the returned bytes stable for the consumers and flags when each byte matches the current address. It sits between the sound board's ROM_A/WAV_ROM_A outputs and the top-level memory controller.

Parameters:
MEM_AW, 25, width of shared memory address.
CPU_BASE, 25'h0000000, memory byte offset of sound CPU ROM image.
WAV_BASE, 25'h0010000, memory byte offset of WAV sample image.
WAV_STARVE, 4, consecutive WAV losses before WAV gets forced priority (1..15).
TIMEOUT, 255, cycles to wait for I_MEM_ACK before aborting (1..255).

Ports:
W_CLK_24576M  in  1  system clock, 24.576 MHz.
W_RESETn  in  1  reset, asynchronous, active-low.
I_CPU_A  in  12  sound CPU ROM address.
O_CPU_D  out  8  last byte returned for CPU.
O_CPU_VALID  out  1  O_CPU_D corresponds to current I_CPU_A.
I_WAV_A  in  19  WAV sample address.
O_WAV_D  out  8  last byte returned for WAV.
O_WAV_VALID  out  1  O_WAV_D corresponds to current I_WAV_A.
O_MEM_A  out  MEM_AW  shared memory byte address.
O_MEM_RD  out  1  one-cycle read strobe.
I_MEM_D  in  8  memory read data, valid with I_MEM_ACK.
I_MEM_ACK  in  1  one-cycle read-complete pulse.
O_TIMEOUT_ERR  out  1  sticky: a read timed out since reset.

Behaviour:
- Reset (async assert, sync release): state IDLE; O_CPU_D=O_WAV_D=8'h00; both VALIDs 0; O_MEM_RD 0; O_MEM_A 0; O_TIMEOUT_ERR 0; starve count 0; loaded-address registers 0; loaded flags 0.
- Pending: a CPU request is pending when the CPU loaded flag is 0 or the loaded CPU address differs from I_CPU_A. WAV pending is defined the same way.
- O_x_VALID = loaded flag AND (loaded address == current input). This is combinational from registered state and the input.
- FSM states: IDLE, CPU_WAIT, WAV_WAIT.
- IDLE with both pending: CPU wins unless starve count >= WAV_STARVE, in which case WAV wins.
- IDLE with a single request pending: that requester is served.
- On grant: latch the requester's current address as issued address, drive O_MEM_A = BASE + zero-extended address (modulo 2^MEM_AW), pulse O_MEM_RD for exactly one cycle, enter x_WAIT, clear the timeout counter.
- O_MEM_A holds until the next grant.
- Starve count: increments, saturating at 15, when CPU is granted while WAV is pending; clears on every WAV grant.
- x_WAIT on I_MEM_ACK: O_x_D <= I_MEM_D, loaded address <= issued address, loaded flag <= 1, go IDLE. Data becomes visible the cycle after ACK.
- Minimum turnaround is grant (IDLE) -> RD -> ACK -> IDLE, so a new grant is possible the cycle after ACK is consumed.
- x_WAIT timeout: after TIMEOUT cycles without ACK, O_x_D <= 8'hFF, loaded address <= issued address, loaded flag <= 1, O_TIMEOUT_ERR <= 1, go IDLE. A late ACK arriving in IDLE is ignored.
- Input address changes during WAIT: the in-flight read still completes and loads the issued address. VALID stays 0 because of the mismatch, the request is re-pended, and it is re-arbitrated in IDLE.
- I_MEM_ACK arriving in the same cycle as O_MEM_RD is not legal; ACK is only sampled in WAIT states.
- Reset mid-transaction aborts immediately; the memory side must tolerate an abandoned read.

Optional Feature:
Macro: DKONG_SND_ARB_STATS_EN.
- Defined: adds output O_MAX_LAT[7:0], the maximum cycles from a CPU request becoming pending to O_CPU_VALID rising. It saturates at 255, resets to 0, and the measuring counter restarts whenever I_CPU_A changes.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package dkong_snd_arb_pkg holds:
  - state enum typedef (IDLE, CPU_WAIT, WAV_WAIT);
  - requester id typedef;
  - constant TIMEOUT_FILL = 8'hFF;
  - starve counter width.
- One sub-module, dkong_snd_arb_port: per-requester loaded-address/flag/data register, pending and VALID logic. It is instantiated twice, parameterised by address width.

Test Plan:
1. Reset, CPU_A=12'h000, WAV_A=0, memory returns addr[7:0] with ACK 3 cycles after RD -> CPU served first, then WAV. O_CPU_D=8'h00 (BASE+0 low byte) and both VALID high by cycle ~10.
2. Hold both requesters changing address every cycle -> WAV granted at least once per 5 grants (WAV_STARVE=4). Starve count never exceeds 4 at a grant.
3. Change CPU_A from 12'h010 to 12'h011 while CPU_WAIT is in flight -> first ACK does not raise VALID, a second RD is issued with O_MEM_A=CPU_BASE+12'h011, then VALID=1.
4. Never assert ACK for WAV request -> after 255 cycles O_WAV_D=8'hFF, O_WAV_VALID=1, O_TIMEOUT_ERR=1. A later spurious ACK is ignored.
5. WAV_A=19'h7FFFF with WAV_BASE near the top of the memory range -> O_MEM_A wraps modulo 2^MEM_AW, with no X values.
6. Assert W_RESETn=0 during WAV_WAIT -> all outputs return to reset values asynchronously, and O_MEM_RD=0 in the same cycle.
